multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller for the multi-cycle MIPS datapath. It has a shared ALU, one unified instruction/data memory port, and IR, A/B and ALUOut holding registers. It steps each instruction through fetch, decode, execute, memory and write-back states. It generates every datapath enable and mux select per state, and stalls on a memory ready handshake. It uses the same opcode map and ALU operation codes as the single-cycle control decoder.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from the cycle after IR is written
- mem_ready  in  1  memory completes the current read/write this cycle
- state  out  4  current state encoding (debug)
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if branch condition true (datapath evaluates zero ^ branch_ne)
- branch_ne  out  1  1 = bne polarity
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory request strobes, held until mem_ready
- ir_write  out  1  IR load
- reg_dst  out  1  1 rd, 0 rt
- mem_to_reg  out  1  1 MDR, 0 ALUOut
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 extended imm, 11 extended imm << 2
- ext_zero  out  1  1 zero-extend imm (andi, ori), else sign-extend
- alu_op  out  3  000 funct, 100 add, 010 and, 001 or, 011 sub, 101 slt
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal_op  out  1  one-cycle pulse when DECODE sees an unmapped opcode

## Operation
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, ALU_WB 7, BRANCH 8, JUMP 9. Codes 10-15 go to FETCH next cycle.
- Outputs are Moore from state plus opcode/mem_ready qualifiers. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_src=00. ir_write=pc_write=mem_ready. Go to DECODE on mem_ready, else hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target into ALUOut). Next state by opcode:
  - 000000 or 000001-000100 → EXEC
  - 000111 or 001000 → MEM_ADDR
  - 001001 or 001010 → BRANCH
  - 001111 → JUMP
  - anything else → FETCH, with illegal_op=1 and instr_done=1
- EXEC: alu_src_a=1. R-type: alu_src_b=00, alu_op=000. addi 100, andi 010, ori 001, slti 101, each with alu_src_b=10. ext_zero=1 for andi/ori. Next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=(opcode==0), instr_done=1. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. On mem_ready: instr_done=1, next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=011, pc_write_cond=1, pc_src=01, branch_ne=(opcode==001010), instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_src=10, instr_done=1. Next state FETCH.

## Timing
- Reset: state=FETCH (0). During and immediately after reset, outputs take FETCH values: mem_read=1, alu_src_b=01, alu_op=100, ir_write=pc_write=mem_ready, all others 0.
- Reset mid-instruction aborts at once. No partial write-back cycle occurs after reset asserts.
- Cycles per instruction with mem_ready held high: R/I-ALU 4, lw 5, sw 4, beq/bne 3, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes, address select and state are held unchanged. ir_write, pc_write and instr_done stay 0 until the ready cycle.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- mem_read and mem_write are never both 1.
- At most one of pc_write or pc_write_cond is asserted in any cycle.

## Test plan
- Reset then R-type (opcode 000000), mem_ready=1 → states 0,1,6,7,0. reg_write=1 and reg_dst=1 in state 7. instr_done pulses once, in the 4th cycle.
- lw (000111) with mem_ready low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4,0. mem_read=1 and i_or_d=1 throughout state 3. mem_to_reg=1 and reg_write=1 in state 4.
- bne (001010) → states 0,1,8,0. In state 8: pc_write_cond=1, branch_ne=1, alu_op=011, pc_src=01. Same sequence for beq (001001) gives branch_ne=0.
- andi (000010) → in EXEC: alu_op=010, alu_src_b=10, ext_zero=1. In ALU_WB: reg_dst=0.
- Opcode 111111 → states 0,1,0. illegal_op and instr_done pulse in the DECODE cycle. reg_write, mem_write and pc_write never assert.
- Assert rst during MEM_WR of sw (001000) with mem_ready=0 → state immediately 0, mem_write drops to 0 asynchronously, mem_read=1 after reset.

Source files
------------

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/write-back and drives every datapath enable and select.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b000011;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b000100;
  localparam logic [OP_W-1:0] OP_LW    = 6'b000111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b001000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b001001;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b001010;
  localparam logic [OP_W-1:0] OP_J     = 6'b001111;

  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // State register; async reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  assign state = r_state;

  // Next-state and Moore control outputs (qualified by opcode / mem_ready)
  always_comb begin
    w_next_state  = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_op        = ALU_FUNCT;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        alu_op       = ALU_ADD;
        ir_write     = mem_ready;
        pc_write     = mem_ready;
        w_next_state = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next_state = S_EXEC;
          OP_LW, OP_SW:                                w_next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                              w_next_state = S_BRANCH;
          OP_J:                                        w_next_state = S_JUMP;
          default: begin
            illegal_op   = 1'b1;
            instr_done   = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_next_state = S_ALU_WB;
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_ANDI: begin alu_op = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin alu_op = ALU_OR;  ext_zero = 1'b1; end
          OP_SLTI: alu_op = ALU_SLT;
          default: begin alu_op = ALU_FUNCT; alu_src_b = 2'b00; end
        endcase
      end

      S_ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        instr_done = 1'b1;
      end

      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = ALU_ADD;
        w_next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read     = 1'b1;
        i_or_d       = 1'b1;
        w_next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end

      S_MEM_WR: begin
        mem_write    = 1'b1;
        i_or_d       = 1'b1;
        instr_done   = mem_ready;
        w_next_state = mem_ready ? S_FETCH : S_MEM_WR;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end

      default: w_next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control; expected control words are
// hand-built constants in the field order of w_ctl below.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [3:0] state;
  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, ext_zero;
  logic       instr_done, illegal_op;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .state(state),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // pw pwc bne pc_src iod mr mw irw rdst m2r rw asa asb ez aop done ill
  logic [20:0] w_ctl;
  assign w_ctl = {pc_write, pc_write_cond, branch_ne, pc_src, i_or_d, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, ext_zero, alu_op, instr_done, illegal_op};

  localparam logic [20:0] C_FETCH0  = 21'b0_0_0_00_0_1_0_0_0_0_0_0_01_0_100_0_0;
  localparam logic [20:0] C_FETCH1  = 21'b1_0_0_00_0_1_0_1_0_0_0_0_01_0_100_0_0;
  localparam logic [20:0] C_DEC     = 21'b0_0_0_00_0_0_0_0_0_0_0_0_11_0_100_0_0;
  localparam logic [20:0] C_DEC_ILL = 21'b0_0_0_00_0_0_0_0_0_0_0_0_11_0_100_1_1;
  localparam logic [20:0] C_EX_R    = 21'b0_0_0_00_0_0_0_0_0_0_0_1_00_0_000_0_0;
  localparam logic [20:0] C_EX_ADDI = 21'b0_0_0_00_0_0_0_0_0_0_0_1_10_0_100_0_0;
  localparam logic [20:0] C_EX_ANDI = 21'b0_0_0_00_0_0_0_0_0_0_0_1_10_1_010_0_0;
  localparam logic [20:0] C_EX_ORI  = 21'b0_0_0_00_0_0_0_0_0_0_0_1_10_1_001_0_0;
  localparam logic [20:0] C_EX_SLTI = 21'b0_0_0_00_0_0_0_0_0_0_0_1_10_0_101_0_0;
  localparam logic [20:0] C_WB_R    = 21'b0_0_0_00_0_0_0_0_1_0_1_0_00_0_000_1_0;
  localparam logic [20:0] C_WB_I    = 21'b0_0_0_00_0_0_0_0_0_0_1_0_00_0_000_1_0;
  localparam logic [20:0] C_MADDR   = 21'b0_0_0_00_0_0_0_0_0_0_0_1_10_0_100_0_0;
  localparam logic [20:0] C_MRD     = 21'b0_0_0_00_1_1_0_0_0_0_0_0_00_0_000_0_0;
  localparam logic [20:0] C_MWB     = 21'b0_0_0_00_0_0_0_0_0_1_1_0_00_0_000_1_0;
  localparam logic [20:0] C_MWR0    = 21'b0_0_0_00_1_0_1_0_0_0_0_0_00_0_000_0_0;
  localparam logic [20:0] C_MWR1    = 21'b0_0_0_00_1_0_1_0_0_0_0_0_00_0_000_1_0;
  localparam logic [20:0] C_BNE     = 21'b0_1_1_01_0_0_0_0_0_0_0_1_00_0_011_1_0;
  localparam logic [20:0] C_BEQ     = 21'b0_1_0_01_0_0_0_0_0_0_0_1_00_0_011_1_0;
  localparam logic [20:0] C_JUMP    = 21'b1_0_0_10_0_0_0_0_0_0_0_0_00_0_000_1_0;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [20:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(logic [5:0] op, logic rdy, logic [3:0] st, logic [20:0] ctl);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-type
    vecs.push_back(mk(6'b000000, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b000000, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000000, 1'b1, 4'd6, C_EX_R));
    vecs.push_back(mk(6'b000000, 1'b1, 4'd7, C_WB_R));
    // lw with two wait cycles in MEM_RD
    vecs.push_back(mk(6'b000111, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b000111, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000111, 1'b1, 4'd2, C_MADDR));
    vecs.push_back(mk(6'b000111, 1'b0, 4'd3, C_MRD));
    vecs.push_back(mk(6'b000111, 1'b0, 4'd3, C_MRD));
    vecs.push_back(mk(6'b000111, 1'b1, 4'd3, C_MRD));
    vecs.push_back(mk(6'b000111, 1'b1, 4'd4, C_MWB));
    // bne, beq
    vecs.push_back(mk(6'b001010, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b001010, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b001010, 1'b1, 4'd8, C_BNE));
    vecs.push_back(mk(6'b001001, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b001001, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b001001, 1'b0, 4'd8, C_BEQ));
    // andi
    vecs.push_back(mk(6'b000010, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b000010, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000010, 1'b1, 4'd6, C_EX_ANDI));
    vecs.push_back(mk(6'b000010, 1'b1, 4'd7, C_WB_I));
    // addi with a stalled fetch; mem_ready low in EXEC is ignored
    vecs.push_back(mk(6'b000001, 1'b0, 4'd0, C_FETCH0));
    vecs.push_back(mk(6'b000001, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b000001, 1'b0, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000001, 1'b0, 4'd6, C_EX_ADDI));
    vecs.push_back(mk(6'b000001, 1'b0, 4'd7, C_WB_I));
    // ori, slti
    vecs.push_back(mk(6'b000011, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b000011, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000011, 1'b1, 4'd6, C_EX_ORI));
    vecs.push_back(mk(6'b000011, 1'b1, 4'd7, C_WB_I));
    vecs.push_back(mk(6'b000100, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b000100, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b000100, 1'b1, 4'd6, C_EX_SLTI));
    vecs.push_back(mk(6'b000100, 1'b1, 4'd7, C_WB_I));
    // sw with one wait cycle
    vecs.push_back(mk(6'b001000, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b001000, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b001000, 1'b1, 4'd2, C_MADDR));
    vecs.push_back(mk(6'b001000, 1'b0, 4'd5, C_MWR0));
    vecs.push_back(mk(6'b001000, 1'b1, 4'd5, C_MWR1));
    // j
    vecs.push_back(mk(6'b001111, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b001111, 1'b1, 4'd1, C_DEC));
    vecs.push_back(mk(6'b001111, 1'b1, 4'd9, C_JUMP));
    // illegal opcodes
    vecs.push_back(mk(6'b111111, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b111111, 1'b1, 4'd1, C_DEC_ILL));
    vecs.push_back(mk(6'b000101, 1'b1, 4'd0, C_FETCH1));
    vecs.push_back(mk(6'b000101, 1'b1, 4'd1, C_DEC_ILL));
    vecs.push_back(mk(6'b000000, 1'b0, 4'd0, C_FETCH0));

    // Reset values, with mem_ready qualifying ir_write/pc_write during reset
    rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl_rdy0", 32'(w_ctl), 32'(C_FETCH0));
    mem_ready = 1'b1;
    #1;
    chk("reset_ctl_rdy1", 32'(w_ctl), 32'(C_FETCH1));
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      opcode    = vecs[i].op;
      mem_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(w_ctl), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_excl", i),
          32'({mem_read & mem_write, pc_write & pc_write_cond}), 32'd0);
      step();
    end

    // Reset asserted during a stalled sw write: strobe drops at once
    opcode = 6'b001000; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_pre_rst_state", 32'(state), 32'd5);
    chk("sw_pre_rst_mw", 32'(mem_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("sw_rst_state", 32'(state), 32'd0);
    chk("sw_rst_mw", 32'(mem_write), 32'd0);
    chk("sw_rst_mr", 32'(mem_read), 32'd1);
    step();
    chk("sw_rst_hold_ctl", 32'(w_ctl), 32'(C_FETCH0));
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("sw_post_rst_state", 32'(state), 32'd0);

    // Reset in ALU_WB of R-type: no write-back once reset asserts
    mem_ready = 1'b1; opcode = 6'b000000;
    step(); step(); step();
    @(negedge clk);
    chk("r_pre_rst_state", 32'(state), 32'd7);
    chk("r_pre_rst_rw", 32'(reg_write), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("r_rst_state", 32'(state), 32'd0);
    chk("r_rst_rw", 32'(reg_write), 32'd0);
    chk("r_rst_ctl", 32'(w_ctl), 32'(C_FETCH1));
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("r_post_rst_state", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
